// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready front end for a single-port OpenRAM macro, with a clear sweep
// that writes INIT_VALUE to every entry after reset or on demand.
module sram_port_ctrl #(
  parameter int DATA_WIDTH = 23,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);
  typedef enum logic [1:0] {RST_WAIT, INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic run, slot, accept;
  assign run = state == RUN;
  // a new access is only safe once the pending response leaves this cycle
  assign slot = !rsp_valid || rsp_ready;
  assign req_ready = run && !clear && slot;
  assign accept = req_valid && req_ready;
  assign init_done = run;
  assign rsp_rdata = dout0;
  always_comb begin
    state_nxt = state;
    csb0 = 1'b1;
    web0 = 1'b1;
    addr0 = '0;
    din0 = '0;
    case (state)
      RST_WAIT: state_nxt = INIT;
      INIT: begin
        csb0 = 1'b0;
        web0 = 1'b0;
        addr0 = cnt;
        din0 = INIT_VALUE;
        state_nxt = &cnt ? RUN : INIT;
      end
      RUN: begin
        state_nxt = clear && slot ? INIT : RUN;
        csb0 = !accept;
        web0 = accept ? !req_we : 1'b1;
        addr0 = accept ? req_addr : '0;
        din0 = accept ? req_wdata : '0;
      end
      default: state_nxt = RST_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_WAIT;
      cnt <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state == INIT && !(&cnt) ? cnt + 1'b1 : '0;
      rsp_valid <= (accept && !req_we) || (rsp_valid && !rsp_ready);
    end
  end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed scenarios plus a randomized phase, checked against a
// transaction-level model (reference array + response queue) and a behavioural macro.
module tb_sram_port_ctrl;
  localparam int DW = 23;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, clear = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, init_done, csb0, web0;
  logic [DW-1:0] rsp_rdata, din0;
  logic [DW-1:0] dout0 = '0;
  logic [AW-1:0] addr0;

  int checks = 0;
  int failures = 0;
  bit go_init;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] pend [$];

  always #5 clk = ~clk;

  sram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .clear(clear), .init_done(init_done), .csb0(csb0), .web0(web0),
    .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  // macro: captures the port at posedge, performs the access and drives dout0 at the negedge
  logic [DW-1:0] mem [DEPTH];
  logic m_sel = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  initial foreach (mem[i]) mem[i] = DW'($urandom);
  always @(posedge clk) begin
    m_sel <= !csb0;
    m_we <= !web0;
    m_addr <= addr0;
    m_din <= din0;
  end
  always @(negedge clk) if (m_sel) begin
    if (m_we) begin
      mem[m_addr] <= m_din;
      dout0 <= m_din;
    end else dout0 <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one RUN-state cycle: called at posedge+1 with inputs applied, checks after the negedge
  task automatic tick();
    bit has, rdy, acc;
    #6;
    has = pend.size() != 0;
    rdy = !clear && (!has || rsp_ready);
    acc = req_valid && rdy;
    chk("init_done", init_done, 1);
    chk("rsp_valid", rsp_valid, has);
    if (has) chk("rsp_rdata", rsp_rdata, pend[0]);
    chk("req_ready", req_ready, rdy);
    chk("csb0", csb0, !acc);
    if (acc) begin
      chk("web0", web0, !req_we);
      chk("addr0", addr0, req_addr);
      if (req_we) chk("din0", din0, req_wdata);
    end else begin
      chk("idle_web0", web0, 1);
      chk("idle_addr0", addr0, 0);
    end
    go_init = clear && (!has || rsp_ready);
    if (has && rsp_ready) void'(pend.pop_front());
    if (acc && req_we) ref_mem[req_addr] = req_wdata;
    else if (acc) pend.push_back(ref_mem[req_addr]);
    if (go_init) pend.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input int a, input int d, input bit rr, input bit clr);
    req_valid = v;
    req_we = we;
    req_addr = a[AW-1:0];
    req_wdata = d[DW-1:0];
    rsp_ready = rr;
    clear = clr;
    tick();
  endtask

  // optional RST_WAIT cycle, then DEPTH sweep writes; request inputs are left active to prove they are ignored
  task automatic expect_sweep(input bit with_wait);
    clear = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    rsp_ready = 1'b1;
    if (with_wait) begin
      #6;
      chk("wait_csb0", csb0, 1);
      chk("wait_init_done", init_done, 0);
      chk("wait_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      #6;
      chk("sweep_csb0", csb0, 0);
      chk("sweep_web0", web0, 0);
      chk("sweep_addr0", addr0, i);
      chk("sweep_din0", din0, INIT);
      chk("sweep_init_done", init_done, 0);
      chk("sweep_req_ready", req_ready, 0);
      chk("sweep_rsp_valid", rsp_valid, 0);
      @(posedge clk);
      #1;
    end
    foreach (ref_mem[i]) ref_mem[i] = INIT;
    pend.delete();
  endtask

  initial begin
    #1;
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // T1: reset release sweep, then a read of a cleared entry
    expect_sweep(1);
    drive(1, 0, 7, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    // T2: write then immediate read of the same address
    drive(1, 1, 3, 'h5A5A5, 1, 0);
    drive(1, 0, 3, 0, 1, 0);
    chk("t2_rdata", rsp_rdata, 'h5A5A5);
    drive(0, 0, 0, 0, 1, 0);
    // T3: back-to-back reads
    drive(1, 1, 1, 'h11, 1, 0);
    drive(1, 1, 2, 'h22, 1, 0);
    drive(1, 1, 3, 'h33, 1, 0);
    for (int i = 1; i <= 3; i++) drive(1, 0, i, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    // T4: stalled response blocks a pending write
    drive(1, 0, 2, 0, 0, 0);
    repeat (5) drive(1, 1, 2, 'h777, 0, 0);
    drive(1, 1, 2, 'h777, 1, 0);
    drive(1, 0, 2, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    // T5: clear waits for the unconsumed response, then every entry reads back INIT_VALUE
    drive(1, 0, 5, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("t5_go_init", go_init, 1);
    expect_sweep(0);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, i, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    // T6: reset in the middle of a clear sweep
    drive(1, 1, 12, 'h1234, 1, 0);
    drive(0, 0, 0, 0, 1, 1);
    clear = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t6_addr9", addr0, 9);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_csb0", csb0, 1);
    chk("t6_rst_init_done", init_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_sweep(1);
    drive(1, 0, 12, 0, 1, 0);
    // randomized traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            int'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      if (go_init) expect_sweep(0);
    end
    drive(0, 0, 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
